// File: rtl/multicycle_control_unit.sv
// Main sequencing FSM of the multicycle CPU: walks each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath enable and mux select.
module multicycle_control_unit #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [OPW-1:0] Op,
  input  logic           Zero,
  output logic           PCWrite,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic [STW-1:0] State
);

  localparam logic [STW-1:0] S_FETCH  = STW'(0);
  localparam logic [STW-1:0] S_DECODE = STW'(1);
  localparam logic [STW-1:0] S_MEMADR = STW'(2);
  localparam logic [STW-1:0] S_MEMRD  = STW'(3);
  localparam logic [STW-1:0] S_MEMWB  = STW'(4);
  localparam logic [STW-1:0] S_MEMWR  = STW'(5);
  localparam logic [STW-1:0] S_EXEC   = STW'(6);
  localparam logic [STW-1:0] S_RWB    = STW'(7);
  localparam logic [STW-1:0] S_BRANCH = STW'(8);
  localparam logic [STW-1:0] S_ADDIEX = STW'(9);
  localparam logic [STW-1:0] S_ADDIWB = STW'(10);
  localparam logic [STW-1:0] S_JUMP   = STW'(11);

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

  logic [STW-1:0] state_q;
  logic [STW-1:0] state_d;
  logic           is_bne_q;

  logic           pc_write_raw;
  logic           iord_raw;
  logic           mem_read_raw;
  logic           mem_write_raw;
  logic           ir_write_raw;
  logic           reg_dst_raw;
  logic           mem_to_reg_raw;
  logic           reg_write_raw;
  logic           alu_src_a_raw;
  logic [1:0]     alu_src_b_raw;
  logic [1:0]     alu_op_raw;
  logic [1:0]     pc_source_raw;

  // State register; the BEQ/BNE flag is captured in DECODE so BRANCH ignores Op.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH;
      is_bne_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        is_bne_q <= (Op == OP_BNE);
      end
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if ((Op == OP_LW) || (Op == OP_SW)) state_d = S_MEMADR;
        else if (Op == OP_R)                state_d = S_EXEC;
        else if ((Op == OP_BEQ) || (Op == OP_BNE)) state_d = S_BRANCH;
        else if (Op == OP_ADDI)             state_d = S_ADDIEX;
        else if (Op == OP_J)                state_d = S_JUMP;
        else                                state_d = S_FETCH;
      end
      S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_raw   = 1'b0;
    iord_raw       = 1'b0;
    mem_read_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    ir_write_raw   = 1'b0;
    reg_dst_raw    = 1'b0;
    mem_to_reg_raw = 1'b0;
    reg_write_raw  = 1'b0;
    alu_src_a_raw  = 1'b0;
    alu_src_b_raw  = 2'b00;
    alu_op_raw     = 2'b00;
    pc_source_raw  = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_raw  = 1'b1;
        ir_write_raw  = 1'b1;
        pc_write_raw  = 1'b1;
        alu_src_b_raw = 2'b01;
      end
      S_DECODE: alu_src_b_raw = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a_raw = 1'b1;
        alu_src_b_raw = 2'b10;
      end
      S_MEMRD: begin
        mem_read_raw = 1'b1;
        iord_raw     = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        iord_raw      = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw  = 1'b1;
        mem_to_reg_raw = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_raw = 1'b1;
        alu_op_raw    = 2'b10;
      end
      S_RWB: begin
        reg_write_raw = 1'b1;
        reg_dst_raw   = 1'b1;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      S_BRANCH: begin
        alu_src_a_raw = 1'b1;
        alu_op_raw    = 2'b01;
        pc_source_raw = 2'b01;
        pc_write_raw  = is_bne_q ? ~Zero : Zero;
      end
      S_JUMP: begin
        pc_write_raw  = 1'b1;
        pc_source_raw = 2'b10;
      end
      default: ;
    endcase
  end

  // Write-type enables are held off during reset so an abandoned instruction never commits.
  assign PCWrite  = pc_write_raw  & ~reset;
  assign MemRead  = mem_read_raw  & ~reset;
  assign MemWrite = mem_write_raw & ~reset;
  assign IRWrite  = ir_write_raw  & ~reset;
  assign RegWrite = reg_write_raw & ~reset;
  assign IorD     = iord_raw;
  assign RegDst   = reg_dst_raw;
  assign MemtoReg = mem_to_reg_raw;
  assign ALUSrcA  = alu_src_a_raw;
  assign ALUSrcB  = alu_src_b_raw;
  assign ALUOp    = alu_op_raw;
  assign PCSource = pc_source_raw;
  assign State    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected output table, checked every cycle.
module tb_multicycle_control_unit;
  localparam int W = 19;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

  logic       clock;
  logic       reset;
  logic [5:0] Op;
  logic       Zero;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] dut_vec;
  int total = 0;
  int bad = 0;

  multicycle_control_unit dut (
    .clock(clock), .reset(reset), .Op(Op), .Zero(Zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .State(State)
  );

  assign dut_vec = {State, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                    RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: output vector assembled from named fields
  function automatic logic [W-1:0] mk(input int st, input bit pcw, input bit iord, input bit mr,
                                      input bit mw, input bit irw, input bit rd, input bit m2r,
                                      input bit rw, input bit asa, input logic [1:0] asb,
                                      input logic [1:0] aop, input logic [1:0] pcs);
    logic [3:0] s4;
    s4 = 4'(st);
    return {s4, pcw, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs};
  endfunction

  function automatic int n_steps(input logic [5:0] op);
    if (op == LW) return 5;
    if (op == SW || op == RT || op == ADDI) return 4;
    if (op == BEQ || op == BNE || op == JMP) return 3;
    return 2;
  endfunction

  // Expected outputs for cycle idx of an instruction with the given opcode
  function automatic logic [W-1:0] step_vec(input logic [5:0] op, input int idx, input bit zero);
    if (idx == 0) return mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    if (idx == 1) return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    if (op == LW || op == SW) begin
      if (idx == 2) return mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
      if (op == SW) return mk(5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      if (idx == 3) return mk(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      return mk(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
    end
    if (op == RT) begin
      if (idx == 2) return mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
      return mk(7, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    end
    if (op == ADDI) begin
      if (idx == 2) return mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
      return mk(10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    end
    if (op == BEQ || op == BNE)
      return mk(8, (op == BEQ) ? zero : !zero, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
    return mk(11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
  endfunction

  // Write-type enables suppressed while reset is high
  function automatic logic [W-1:0] under_reset(input logic [W-1:0] v);
    logic [W-1:0] m;
    m = '0;
    m[14] = 1'b1; m[12] = 1'b1; m[11] = 1'b1; m[10] = 1'b1; m[7] = 1'b1;
    return v & ~m;
  endfunction

  // Scoreboard: compare every cycle that has an expectation
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      total++;
      if (dut_vec !== e) begin
        bad++;
        $display("FAIL cycle_vec t=%0t got=%h exp=%h (state got %0d exp %0d)",
                 $time, dut_vec, e, State, e[18:15]);
      end
      total++;
      if ((MemRead && MemWrite) || (RegWrite && MemWrite)) begin
        bad++;
        $display("FAIL exclusive_enables t=%0t MemRead=%b MemWrite=%b RegWrite=%b required no overlap",
                 $time, MemRead, MemWrite, RegWrite);
      end
    end
  end

  task automatic check_lit(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, req);
    end
  endtask

  // Driver: Op carries junk except in the cycles where it is sampled
  task automatic run_instr(input logic [5:0] op, input bit zero, input logic [5:0] junk);
    int n;
    n = n_steps(op);
    for (int i = 0; i < n; i++) begin
      Op = ((i == 1) || (i == 2 && (op == LW || op == SW))) ? op : junk;
      Zero = zero;
      exp_q.push_back(step_vec(op, i, zero));
      @(posedge clock); #1;
    end
  endtask

  // SW aborted by a 2-cycle reset while in MEMWR
  task automatic reset_in_memwr();
    for (int i = 0; i < 3; i++) begin
      Op = SW;
      exp_q.push_back(step_vec(SW, i, 1'b0));
      @(posedge clock); #1;
    end
    reset = 1'b1;
    exp_q.push_back(under_reset(step_vec(SW, 3, 1'b0)));
    @(posedge clock); #1;
    exp_q.push_back(under_reset(step_vec(RT, 0, 1'b0)));
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    Op = 6'b0;
    Zero = 1'b0;
    check_lit("model_lw_len", W'(n_steps(LW)), W'(5));
    check_lit("model_j_len", W'(n_steps(JMP)), W'(3));
    check_lit("model_nop_len", W'(n_steps(6'b111111)), W'(2));
    check_lit("model_fetch", step_vec(LW, 0, 1'b0), 19'h05410);
    check_lit("model_lw_wb", step_vec(LW, 4, 1'b0), 19'h20180);
    check_lit("model_jump", step_vec(JMP, 2, 1'b0), 19'h5C002);
    check_lit("model_beq_taken", step_vec(BEQ, 2, 1'b1), 19'h44045);
    check_lit("model_bne_taken", step_vec(BNE, 2, 1'b0), 19'h44045);

    @(posedge clock); #1;
    exp_q.push_back(under_reset(step_vec(RT, 0, 1'b0)));
    @(posedge clock); #1;
    reset = 1'b0;

    run_instr(LW,   1'b0, ~LW);
    run_instr(SW,   1'b1, ~SW);
    run_instr(RT,   1'b0, LW);
    run_instr(ADDI, 1'b0, JMP);
    run_instr(BEQ,  1'b1, BNE);
    run_instr(BEQ,  1'b0, BNE);
    run_instr(BNE,  1'b0, BEQ);
    run_instr(BNE,  1'b1, BEQ);
    run_instr(JMP,  1'b0, RT);
    run_instr(6'b111111, 1'b0, RT);
    run_instr(6'b000001, 1'b1, LW);
    reset_in_memwr();
    run_instr(LW,   1'b0, SW);
    run_instr(ADDI, 1'b1, ADDI);

    @(negedge clock); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d entries left, exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
